// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage: FSM encoding, MEMWB control
// bundle and wait-counter sizing.
package mem_stage_pkg;

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t BUSY = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT = 64;

   // Wait counter must hold 0..TIMEOUT; a zero timeout still needs one bit.
   function automatic int cnt_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

   localparam int CNT_W = cnt_width(DEFAULT_TIMEOUT);

   typedef struct packed {
      logic wb_valid;
      logic reg_write;
      logic mem_to_reg;
      logic ret;
   } wb_ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for an outstanding memory request; flags the cycle
// in which the ack deadline expires without an ack.
module mem_wait_timer
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int          W       = cnt_width(TIMEOUT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic busy_i,
   input  logic ack_i,
   output logic timeout_hit_o
);

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] LIMIT   = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic         ENABLED = (TIMEOUT != 0);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (busy_i && !ack_i && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign timeout_hit_o = ENABLED & busy_i & ~ack_i & (count_q == LIMIT);

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with req/ack memory handshake, pipeline stall while a
// request is outstanding, ack timeout, and the MEMWB register.
module mem_stage_hs
   import mem_stage_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter int          ADDR_W  = 12,
   parameter int          REG_W   = 5,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_src,
   input  logic              call_in,
   input  logic              ret_in,
   input  logic [REG_W-1:0]  dest_reg_in,
   input  logic [DATA_W-1:0] alu_addr,
   input  logic [ADDR_W-1:0] non_alu_addr,
   input  logic [DATA_W-1:0] mem_write_data,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_err,
   output logic              wb_valid,
   output logic              reg_write_out,
   output logic              mem_to_reg_out,
   output logic              ret_out,
   output logic [REG_W-1:0]  dest_reg_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] mem_read_data
);

   typedef struct packed {
      wb_ctrl_t          ctrl;
      logic [REG_W-1:0]  dest_reg;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data;
   } memwb_t;

   // Writeback fields parked while the request is outstanding.
   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic              ret;
      logic              is_rd;
      logic [REG_W-1:0]  dest_reg;
      logic [DATA_W-1:0] alu_result;
   } req_t;

   logic              is_wr;
   logic              is_rd;
   logic              is_mem;
   logic [ADDR_W-1:0] addr_sel;
   logic              busy;
   logic              timeout_hit;
   logic              timer_clr;

   state_t            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   req_t              cap_q, cap_d;
   memwb_t            wb_q, wb_d;

   assign is_wr    = mem_write | call_in;
   assign is_rd    = (mem_read | ret_in) & ~is_wr;
   assign is_mem   = ex_valid & (is_wr | is_rd);
   assign addr_sel = (mem_src | call_in) ? non_alu_addr : alu_addr[ADDR_W-1:0];

   assign busy      = (state_q == BUSY);
   assign timer_clr = (state_q == IDLE) & is_mem;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .clr_i         (timer_clr),
      .busy_i        (busy),
      .ack_i         (mem_ack),
      .timeout_hit_o (timeout_hit)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cap_d       = cap_q;
      wb_d        = wb_q;
      case (state_q)
         IDLE: begin
            if (is_mem) begin
               state_d     = BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = is_wr;
               mem_addr_d  = addr_sel;
               mem_wdata_d = mem_write_data;
               cap_d       = '{reg_write: reg_write_in, mem_to_reg: mem_to_reg_in,
                               ret: ret_in, is_rd: is_rd, dest_reg: dest_reg_in,
                               alu_result: alu_addr};
               wb_d.ctrl.wb_valid  = 1'b0;
               wb_d.ctrl.reg_write = 1'b0;
            end else if (ex_valid) begin
               wb_d.ctrl       = '{wb_valid: 1'b1, reg_write: reg_write_in,
                                   mem_to_reg: mem_to_reg_in, ret: ret_in};
               wb_d.dest_reg   = dest_reg_in;
               wb_d.alu_result = alu_addr;
            end else begin
               wb_d.ctrl.wb_valid  = 1'b0;
               wb_d.ctrl.reg_write = 1'b0;
            end
         end
         BUSY: begin
            // Ack beats timeout; a timed-out access retires with zero data.
            if (mem_ack || timeout_hit) begin
               state_d         = IDLE;
               mem_req_d       = 1'b0;
               wb_d.ctrl       = '{wb_valid: 1'b1, reg_write: cap_q.reg_write,
                                   mem_to_reg: cap_q.mem_to_reg, ret: cap_q.ret};
               wb_d.dest_reg   = cap_q.dest_reg;
               wb_d.alu_result = cap_q.alu_result;
               if (mem_ack) begin
                  if (cap_q.is_rd) begin
                     wb_d.read_data = mem_rdata;
                  end
               end else begin
                  wb_d.read_data = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cap_q       <= '0;
         wb_q        <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cap_q       <= cap_d;
         wb_q        <= wb_d;
      end
   end

   assign stall = ~rst & (((state_q == IDLE) & is_mem) |
                          (busy & ~mem_ack & ~timeout_hit));
   assign mem_err = ~rst & timeout_hit;

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   assign wb_valid       = wb_q.ctrl.wb_valid;
   assign reg_write_out  = wb_q.ctrl.reg_write;
   assign mem_to_reg_out = wb_q.ctrl.mem_to_reg;
   assign ret_out        = wb_q.ctrl.ret;
   assign dest_reg_out   = wb_q.dest_reg;
   assign alu_result_out = wb_q.alu_result;
   assign mem_read_data  = wb_q.read_data;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: driver tasks push expected writebacks,
// a monitor pops and compares whenever wb_valid is seen.
module tb_mem_stage_hs;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;
   localparam int REG_W  = 5;
   localparam int EXP_W  = 3 + REG_W + 2 * DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              ex_valid, reg_write_in, mem_to_reg_in, mem_read, mem_write;
   logic              mem_src, call_in, ret_in;
   logic [REG_W-1:0]  dest_reg_in;
   logic [DATA_W-1:0] alu_addr;
   logic [ADDR_W-1:0] non_alu_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              stall, mem_req, mem_we, mem_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              wb_valid, reg_write_out, mem_to_reg_out, ret_out;
   logic [REG_W-1:0]  dest_reg_out;
   logic [DATA_W-1:0] alu_result_out, mem_read_data;

   logic [EXP_W-1:0]  exp_q[$];
   logic [DATA_W-1:0] last_rd;
   int                test_cnt = 0;
   int                fail_cnt = 0;

   mem_stage_hs #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .REG_W (REG_W), .TIMEOUT (4)
   ) dut (
      .clk (clk), .rst (rst), .ex_valid (ex_valid),
      .reg_write_in (reg_write_in), .mem_to_reg_in (mem_to_reg_in),
      .mem_read (mem_read), .mem_write (mem_write), .mem_src (mem_src),
      .call_in (call_in), .ret_in (ret_in), .dest_reg_in (dest_reg_in),
      .alu_addr (alu_addr), .non_alu_addr (non_alu_addr),
      .mem_write_data (mem_write_data), .stall (stall), .mem_req (mem_req),
      .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
      .mem_ack (mem_ack), .mem_rdata (mem_rdata), .mem_err (mem_err),
      .wb_valid (wb_valid), .reg_write_out (reg_write_out),
      .mem_to_reg_out (mem_to_reg_out), .ret_out (ret_out),
      .dest_reg_out (dest_reg_out), .alu_result_out (alu_result_out),
      .mem_read_data (mem_read_data)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish, tests=%0d", test_cnt);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      ex_valid = 0; reg_write_in = 0; mem_to_reg_in = 0; mem_read = 0;
      mem_write = 0; mem_src = 0; call_in = 0; ret_in = 0; dest_reg_in = '0;
      alu_addr = '0; non_alu_addr = '0; mem_write_data = '0;
   endtask

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      test_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic rw, input logic m2r, input logic rt,
                           input logic [REG_W-1:0] dst,
                           input logic [DATA_W-1:0] alu,
                           input logic [DATA_W-1:0] rd);
      exp_q.push_back({rw, m2r, rt, dst, alu, rd});
      last_rd = rd;
   endtask

   // Inputs already describe a memory op in IDLE. Runs n_wait BUSY cycles
   // without ack, then acks with rdata and retires.
   task automatic mem_op(input string name, input int n_wait,
                         input logic [DATA_W-1:0] rdata, input logic exp_we,
                         input logic [ADDR_W-1:0] exp_addr,
                         input logic [DATA_W-1:0] exp_wdata);
      #1;
      check({name, " idle stall"}, 64'(stall), 64'd1);
      for (int i = 0; i < n_wait; i++) begin
         tick(); #1;
         check({name, " wait stall"}, 64'(stall), 64'd1);
         check({name, " wait req"}, 64'(mem_req), 64'd1);
      end
      tick();
      mem_ack = 1; mem_rdata = rdata;
      #1;
      check({name, " req"}, 64'(mem_req), 64'd1);
      check({name, " we"}, 64'(mem_we), 64'(exp_we));
      check({name, " addr"}, 64'(mem_addr), 64'(exp_addr));
      check({name, " wdata"}, 64'(mem_wdata), 64'(exp_wdata));
      check({name, " ack stall"}, 64'(stall), 64'd0);
      check({name, " ack err"}, 64'(mem_err), 64'd0);
      tick();
      mem_ack = 0; mem_rdata = '0;
      clear_in();
      #1;
      check({name, " req drop"}, 64'(mem_req), 64'd0);
   endtask

   // scoreboard monitor
   always begin
      @(posedge clk);
      #3;
      if (!rst && wb_valid) begin
         test_cnt++;
         if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL wb unexpected: dest=%0d alu=0x%0h rd=0x%0h expected none",
                     dest_reg_out, alu_result_out, mem_read_data);
         end else begin
            logic [EXP_W-1:0] e;
            logic [EXP_W-1:0] a;
            e = exp_q.pop_front();
            a = {reg_write_out, mem_to_reg_out, ret_out, dest_reg_out,
                 alu_result_out, mem_read_data};
            if (a !== e) begin
               fail_cnt++;
               $display("FAIL wb fields: got 0x%0h expected 0x%0h", a, e);
            end
         end
      end
   end

   // stimulus
   initial begin
      clear_in();
      mem_ack = 0; mem_rdata = '0; last_rd = '0;
      rst = 1;
      ex_valid = 1; mem_read = 1;
      #1;
      check("rst stall", 64'(stall), 64'd0);
      tick(); tick();
      check("rst req", 64'(mem_req), 64'd0);
      check("rst we/err", 64'({mem_we, mem_err}), 64'd0);
      check("rst addr", 64'(mem_addr), 64'd0);
      check("rst wdata", 64'(mem_wdata), 64'd0);
      check("rst wb ctrl", 64'({wb_valid, reg_write_out, mem_to_reg_out, ret_out}), 64'd0);
      check("rst wb data", 64'({dest_reg_out, alu_result_out}), 64'd0);
      check("rst rd", 64'(mem_read_data), 64'd0);
      rst = 0;
      clear_in();

      // plain ALU op
      ex_valid = 1; reg_write_in = 1; dest_reg_in = 7; alu_addr = 32'h0000_1234;
      #1;
      check("alu stall", 64'(stall), 64'd0);
      push_exp(1, 0, 0, 7, 32'h0000_1234, last_rd);
      tick();
      clear_in();
      tick(); #1;
      check("bubble valid", 64'({wb_valid, reg_write_out}), 64'd0);

      // load, ack in the 4th BUSY cycle (also the deadline cycle)
      ex_valid = 1; mem_read = 1; reg_write_in = 1; mem_to_reg_in = 1;
      dest_reg_in = 3; alu_addr = 32'hFFFF_F0A8; mem_write_data = 32'h5;
      push_exp(1, 1, 0, 3, 32'hFFFF_F0A8, 32'hDEAD_BEEF);
      mem_op("load", 3, 32'hDEAD_BEEF, 1'b0, 12'h0A8, 32'h5);

      // ALU op keeps previous read data
      ex_valid = 1; reg_write_in = 1; dest_reg_in = 2; alu_addr = 32'h0000_0099;
      push_exp(1, 0, 0, 2, 32'h0000_0099, last_rd);
      tick();
      clear_in();

      // call push: write to stack address, same-cycle ack
      ex_valid = 1; call_in = 1; non_alu_addr = 12'hFFC; alu_addr = 32'h55;
      mem_write_data = 32'h40;
      push_exp(0, 0, 0, 0, 32'h55, last_rd);
      mem_op("call", 0, 32'hAAAA_AAAA, 1'b1, 12'hFFC, 32'h40);

      // ret pop: read from stack address
      ex_valid = 1; ret_in = 1; mem_src = 1; non_alu_addr = 12'hFFC;
      alu_addr = 32'h66;
      push_exp(0, 0, 1, 0, 32'h66, 32'h0000_0123);
      mem_op("ret", 0, 32'h0000_0123, 1'b0, 12'hFFC, 32'h0);

      // read+write both set: write wins, read data held
      ex_valid = 1; mem_read = 1; mem_write = 1; alu_addr = 32'h0000_0200;
      mem_write_data = 32'h77; dest_reg_in = 4;
      push_exp(0, 0, 0, 4, 32'h0000_0200, last_rd);
      mem_op("rw", 1, 32'hBBBB_BBBB, 1'b1, 12'h200, 32'h77);

      // timeout: no ack for 4 BUSY cycles
      ex_valid = 1; mem_read = 1; reg_write_in = 1; dest_reg_in = 9;
      alu_addr = 32'h10;
      push_exp(1, 0, 0, 9, 32'h10, 32'h0);
      #1;
      check("to idle stall", 64'(stall), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         check("to wait err", 64'({mem_err, stall}), 64'b01);
      end
      tick(); #1;
      check("to err pulse", 64'(mem_err), 64'd1);
      check("to stall release", 64'(stall), 64'd0);
      tick();
      clear_in();
      #1;
      check("to err clear", 64'(mem_err), 64'd0);
      check("to req drop", 64'(mem_req), 64'd0);

      // spurious ack in IDLE
      mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      check("spur stall", 64'(stall), 64'd0);
      tick();
      mem_ack = 0; mem_rdata = '0;
      #1;
      check("spur req", 64'(mem_req), 64'd0);
      check("spur valid", 64'(wb_valid), 64'd0);
      check("spur rd", 64'(mem_read_data), 64'(last_rd));
      ex_valid = 1; reg_write_in = 1; dest_reg_in = 1; alu_addr = 32'hCAFE;
      #1;
      check("post spur stall", 64'(stall), 64'd0);
      push_exp(1, 0, 0, 1, 32'hCAFE, last_rd);
      tick();
      clear_in();

      // reset while BUSY abandons the request
      ex_valid = 1; mem_read = 1; reg_write_in = 1; alu_addr = 32'h20;
      tick(); #1;
      check("rb req", 64'(mem_req), 64'd1);
      rst = 1;
      #1;
      check("rb stall", 64'(stall), 64'd0);
      tick(); #1;
      check("rb req drop", 64'(mem_req), 64'd0);
      check("rb valid", 64'(wb_valid), 64'd0);
      rst = 0;
      clear_in();
      tick(); #1;
      check("rb idle req", 64'(mem_req), 64'd0);
      tick(); tick();

      check("exp queue empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
